// File: rtl/scarv_cop_mem_bridge_if.sv
// Signal bundle between the COP load/store unit, the memory bridge and the split-transaction bus.
// The master view belongs to the bridge, and the slave view to the surrounding LSU and bus environment.
interface scarv_cop_mem_bridge_if;
    logic        cop_mem_cen;
    logic        cop_mem_wen;
    logic [31:0] cop_mem_addr;
    logic [31:0] cop_mem_wdata;
    logic [3:0]  cop_mem_ben;
    logic [31:0] cop_mem_rdata;
    logic        cop_mem_stall;
    logic        cop_mem_error;
    logic        bus_req;
    logic        bus_gnt;
    logic        bus_wen;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_ben;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        bus_err;

    modport master (
        input  cop_mem_cen, cop_mem_wen, cop_mem_addr, cop_mem_wdata, cop_mem_ben,
        input  bus_gnt, bus_rvalid, bus_rdata, bus_err,
        output cop_mem_rdata, cop_mem_stall, cop_mem_error,
        output bus_req, bus_wen, bus_addr, bus_wdata, bus_ben
    );

    modport slave (
        output cop_mem_cen, cop_mem_wen, cop_mem_addr, cop_mem_wdata, cop_mem_ben,
        output bus_gnt, bus_rvalid, bus_rdata, bus_err,
        input  cop_mem_rdata, cop_mem_stall, cop_mem_error,
        input  bus_req, bus_wen, bus_addr, bus_wdata, bus_ben
    );
endinterface

// File: rtl/scarv_cop_mem_bridge.sv
// Bridges the COP stall-style memory port onto a req/gnt + rvalid bus with one transaction outstanding.
// It also checks each address against a window and puts a timeout on the bus response.
module scarv_cop_mem_bridge #(
    parameter logic [31:0] WIN_BASE = 32'h0000_0000,
    parameter logic [31:0] WIN_MASK = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input logic                    g_clk,
    input logic                    g_resetn,
    scarv_cop_mem_bridge_if.master bif
);

    localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t             state_q, state_d;
    logic               bus_req_q, bus_req_d;
    logic               bus_wen_q, bus_wen_d;
    logic [31:0]        bus_addr_q, bus_addr_d;
    logic [31:0]        bus_wdata_q, bus_wdata_d;
    logic [3:0]         bus_ben_q, bus_ben_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               error_q, error_d;
    logic               stall_q, stall_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               orphan_q, orphan_d;

    logic [CNT_W-1:0]   cnt_inc;
    logic               timeout_hit;
    logic               capture;
    logic               in_win;

    // State register and all registered outputs
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_q     <= S_IDLE;
            bus_req_q   <= 1'b0;
            bus_wen_q   <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_wdata_q <= 32'h0;
            bus_ben_q   <= 4'h0;
            rdata_q     <= 32'h0;
            error_q     <= 1'b0;
            stall_q     <= 1'b1;
            cnt_q       <= '0;
            orphan_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_wen_q   <= bus_wen_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_ben_q   <= bus_ben_d;
            rdata_q     <= rdata_d;
            error_q     <= error_d;
            stall_q     <= stall_d;
            cnt_q       <= cnt_d;
            orphan_q    <= orphan_d;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        bus_wen_d   = bus_wen_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_ben_d   = bus_ben_q;
        cnt_d       = cnt_q;
        orphan_d    = orphan_q;
        rdata_d     = 32'h0;
        error_d     = 1'b0;

        cnt_inc     = cnt_q + CNT_W'(1);
        timeout_hit = (TIMEOUT != 0) && (cnt_inc == CNT_W'(TIMEOUT));
        in_win      = (bif.cop_mem_addr & WIN_MASK) == WIN_BASE;
        capture     = bif.cop_mem_cen &&
                      (((state_q == S_IDLE) && !orphan_q) || (state_q == S_RESP));

        // A response to a timed-out transaction is dropped on arrival
        if (orphan_q && bif.bus_rvalid) begin
            orphan_d = 1'b0;
        end

        case (state_q)
            S_IDLE, S_RESP: begin
                if (capture) begin
                    bus_wen_d   = bif.cop_mem_wen;
                    bus_addr_d  = bif.cop_mem_addr;
                    bus_wdata_d = bif.cop_mem_wdata;
                    bus_ben_d   = bif.cop_mem_wen ? bif.cop_mem_ben : 4'hF;
                    cnt_d       = '0;
                    if (in_win) begin
                        state_d = S_REQ;
                    end else begin
                        state_d = S_RESP;
                        error_d = 1'b1;
                    end
                end else if (state_q == S_RESP) begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                cnt_d = cnt_inc;
                if (bif.bus_gnt) begin
                    // Once granted a response is owed, so a timeout now must orphan it
                    if (timeout_hit) begin
                        state_d  = S_RESP;
                        error_d  = 1'b1;
                        orphan_d = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else if (!bif.cop_mem_cen) begin
                    state_d = S_IDLE;
                end else if (timeout_hit) begin
                    state_d = S_RESP;
                    error_d = 1'b1;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_inc;
                if (bif.bus_rvalid && !orphan_q) begin
                    state_d = S_RESP;
                    error_d = bif.bus_err;
                    rdata_d = bus_wen_q ? 32'h0 : bif.bus_rdata;
                end else if (timeout_hit) begin
                    state_d  = S_RESP;
                    error_d  = 1'b1;
                    orphan_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        bus_req_d = (state_d == S_REQ);
        stall_d   = (state_d != S_RESP);
    end

    assign bif.bus_req       = bus_req_q;
    assign bif.bus_wen       = bus_wen_q;
    assign bif.bus_addr      = bus_addr_q;
    assign bif.bus_wdata     = bus_wdata_q;
    assign bif.bus_ben       = bus_ben_q;
    assign bif.cop_mem_rdata = rdata_q;
    assign bif.cop_mem_error = error_q;
    assign bif.cop_mem_stall = stall_q;

endmodule

// File: tb/tb_scarv_cop_mem_bridge.sv
// Directed bench for scarv_cop_mem_bridge: one default instance and one windowed instance with a short timeout.
module tb_scarv_cop_mem_bridge;

    logic g_clk = 1'b0;
    logic g_resetn;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 g_clk = ~g_clk;

    scarv_cop_mem_bridge_if ia ();
    scarv_cop_mem_bridge_if ib ();

    scarv_cop_mem_bridge dut_a (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .bif      (ia)
    );

    scarv_cop_mem_bridge #(
        .WIN_BASE (32'h0001_0000),
        .WIN_MASK (32'hFFFF_0000),
        .TIMEOUT  (4)
    ) dut_b (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .bif      (ib)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge g_clk);
        #1;
    endtask

    // Minimum-latency load on instance A, with cop_mem_cen dropped during the response cycle
    task automatic load_a(input string tag, input logic [31:0] addr,
                          input logic [31:0] data, input logic err);
        ia.cop_mem_cen  = 1'b1;
        ia.cop_mem_wen  = 1'b0;
        ia.cop_mem_addr = addr;
        ia.cop_mem_ben  = 4'h0;
        step();
        chk({tag, ".req"},   32'(ia.bus_req), 32'd1);
        chk({tag, ".addr"},  ia.bus_addr, addr);
        chk({tag, ".ben"},   32'(ia.bus_ben), 32'hF);
        chk({tag, ".stall1"}, 32'(ia.cop_mem_stall), 32'd1);
        ia.bus_gnt = 1'b1;
        step();
        chk({tag, ".req_off"}, 32'(ia.bus_req), 32'd0);
        chk({tag, ".stall2"},  32'(ia.cop_mem_stall), 32'd1);
        ia.bus_gnt    = 1'b0;
        ia.bus_rvalid = 1'b1;
        ia.bus_rdata  = data;
        ia.bus_err    = err;
        step();
        chk({tag, ".stall_rsp"}, 32'(ia.cop_mem_stall), 32'd0);
        chk({tag, ".rdata"},     ia.cop_mem_rdata, data);
        chk({tag, ".err"},       32'(ia.cop_mem_error), 32'(err));
        ia.bus_rvalid  = 1'b0;
        ia.bus_err     = 1'b0;
        ia.cop_mem_cen = 1'b0;
        step();
        chk({tag, ".stall_idle"}, 32'(ia.cop_mem_stall), 32'd1);
        chk({tag, ".rdata_idle"}, ia.cop_mem_rdata, 32'h0);
        chk({tag, ".err_idle"},   32'(ia.cop_mem_error), 32'd0);
    endtask

    initial begin
        g_resetn = 1'b0;
        {ia.cop_mem_cen, ia.cop_mem_wen, ia.cop_mem_addr, ia.cop_mem_wdata, ia.cop_mem_ben} = '0;
        {ia.bus_gnt, ia.bus_rvalid, ia.bus_rdata, ia.bus_err} = '0;
        {ib.cop_mem_cen, ib.cop_mem_wen, ib.cop_mem_addr, ib.cop_mem_wdata, ib.cop_mem_ben} = '0;
        {ib.bus_gnt, ib.bus_rvalid, ib.bus_rdata, ib.bus_err} = '0;
        step();
        step();
        g_resetn = 1'b1;

        // Reset state
        chk("rst.stall",  32'(ia.cop_mem_stall), 32'd1);
        chk("rst.req",    32'(ia.bus_req), 32'd0);
        chk("rst.err",    32'(ia.cop_mem_error), 32'd0);
        chk("rst.rdata",  ia.cop_mem_rdata, 32'h0);
        chk("rst.addr",   ia.bus_addr, 32'h0);
        chk("rst.ben",    32'(ia.bus_ben), 32'h0);
        chk("rst.wen",    32'(ia.bus_wen), 32'd0);
        chk("rst.b_stall", 32'(ib.cop_mem_stall), 32'd1);

        // Test 1: minimum-latency load
        load_a("t1", 32'h0000_0100, 32'hDEAD_BEEF, 1'b0);

        // Test 2: store granted after three cycles; request must hold steady
        ia.cop_mem_cen   = 1'b1;
        ia.cop_mem_wen   = 1'b1;
        ia.cop_mem_addr  = 32'h0000_0204;
        ia.cop_mem_wdata = 32'h0000_A5A5;
        ia.cop_mem_ben   = 4'b0011;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("t2.req",   32'(ia.bus_req), 32'd1);
            chk("t2.wen",   32'(ia.bus_wen), 32'd1);
            chk("t2.addr",  ia.bus_addr, 32'h0000_0204);
            chk("t2.wdata", ia.bus_wdata, 32'h0000_A5A5);
            chk("t2.ben",   32'(ia.bus_ben), 32'h3);
            chk("t2.stall", 32'(ia.cop_mem_stall), 32'd1);
            if (i == 3) ia.bus_gnt = 1'b1;
            step();
        end
        chk("t2.req_off", 32'(ia.bus_req), 32'd0);
        ia.bus_gnt    = 1'b0;
        ia.bus_rvalid = 1'b1;
        ia.bus_rdata  = 32'h1234_5678;
        step();
        chk("t2.stall_rsp", 32'(ia.cop_mem_stall), 32'd0);
        chk("t2.rdata0",    ia.cop_mem_rdata, 32'h0);
        chk("t2.err",       32'(ia.cop_mem_error), 32'd0);
        ia.bus_rvalid  = 1'b0;
        ia.cop_mem_cen = 1'b0;
        step();
        chk("t2.stall_idle", 32'(ia.cop_mem_stall), 32'd1);

        // Test 3: out-of-window load errors at once and never reaches the bus
        ib.cop_mem_cen  = 1'b1;
        ib.cop_mem_wen  = 1'b0;
        ib.cop_mem_addr = 32'h0002_0000;
        step();
        chk("t3.req",   32'(ib.bus_req), 32'd0);
        chk("t3.stall", 32'(ib.cop_mem_stall), 32'd0);
        chk("t3.err",   32'(ib.cop_mem_error), 32'd1);
        chk("t3.rdata", ib.cop_mem_rdata, 32'h0);
        ib.cop_mem_cen = 1'b0;
        step();
        chk("t3.req2",   32'(ib.bus_req), 32'd0);
        chk("t3.stall2", 32'(ib.cop_mem_stall), 32'd1);
        chk("t3.err2",   32'(ib.cop_mem_error), 32'd0);

        // Test 4: granted load times out; the late response is discarded
        ib.cop_mem_cen  = 1'b1;
        ib.cop_mem_addr = 32'h0001_0008;
        step();
        chk("t4.req", 32'(ib.bus_req), 32'd1);
        ib.bus_gnt = 1'b1;
        step();
        ib.bus_gnt = 1'b0;
        chk("t4.wait_req", 32'(ib.bus_req), 32'd0);
        step();
        chk("t4.stall3", 32'(ib.cop_mem_stall), 32'd1);
        step();
        chk("t4.stall4", 32'(ib.cop_mem_stall), 32'd1);
        chk("t4.err4",   32'(ib.cop_mem_error), 32'd0);
        step();
        chk("t4.stall5", 32'(ib.cop_mem_stall), 32'd0);
        chk("t4.err5",   32'(ib.cop_mem_error), 32'd1);
        chk("t4.rdata5", ib.cop_mem_rdata, 32'h0);
        ib.cop_mem_cen = 1'b0;
        step();
        ib.cop_mem_cen  = 1'b1;
        ib.cop_mem_addr = 32'h0001_000C;
        step();
        chk("t4.blocked", 32'(ib.bus_req), 32'd0);
        ib.bus_rvalid = 1'b1;
        ib.bus_rdata  = 32'hDEAD_0000;
        step();
        ib.bus_rvalid = 1'b0;
        chk("t4.blocked2", 32'(ib.bus_req), 32'd0);
        chk("t4.no_rsp",   32'(ib.cop_mem_stall), 32'd1);
        step();
        chk("t4.req_new", 32'(ib.bus_req), 32'd1);
        chk("t4.addr_new", ib.bus_addr, 32'h0001_000C);
        ib.bus_gnt = 1'b1;
        step();
        ib.bus_gnt    = 1'b0;
        ib.bus_rvalid = 1'b1;
        ib.bus_rdata  = 32'hCAFE_0001;
        step();
        chk("t4.stall_new", 32'(ib.cop_mem_stall), 32'd0);
        chk("t4.rdata_new", ib.cop_mem_rdata, 32'hCAFE_0001);
        chk("t4.err_new",   32'(ib.cop_mem_error), 32'd0);
        ib.bus_rvalid  = 1'b0;
        ib.cop_mem_cen = 1'b0;
        step();

        // Test 5: gather, second capture taken in the response cycle
        ia.cop_mem_cen  = 1'b1;
        ia.cop_mem_wen  = 1'b0;
        ia.cop_mem_addr = 32'h0000_0300;
        step();
        chk("t5.req1", 32'(ia.bus_req), 32'd1);
        ia.bus_gnt = 1'b1;
        step();
        ia.bus_gnt    = 1'b0;
        ia.bus_rvalid = 1'b1;
        ia.bus_rdata  = 32'h1111_0300;
        step();
        chk("t5.stall1", 32'(ia.cop_mem_stall), 32'd0);
        chk("t5.rdata1", ia.cop_mem_rdata, 32'h1111_0300);
        ia.bus_rvalid   = 1'b0;
        ia.cop_mem_addr = 32'h0000_0304;
        step();
        chk("t5.req2",    32'(ia.bus_req), 32'd1);
        chk("t5.addr2",   ia.bus_addr, 32'h0000_0304);
        chk("t5.stall_b", 32'(ia.cop_mem_stall), 32'd1);
        ia.bus_gnt = 1'b1;
        step();
        ia.bus_gnt    = 1'b0;
        ia.bus_rvalid = 1'b1;
        ia.bus_rdata  = 32'h2222_0304;
        step();
        chk("t5.stall2", 32'(ia.cop_mem_stall), 32'd0);
        chk("t5.rdata2", ia.cop_mem_rdata, 32'h2222_0304);
        ia.bus_rvalid  = 1'b0;
        ia.cop_mem_cen = 1'b0;
        step();
        chk("t5.idle", 32'(ia.cop_mem_stall), 32'd1);

        // Abort before grant, then a load that returns a bus error
        ia.cop_mem_cen  = 1'b1;
        ia.cop_mem_addr = 32'h0000_0500;
        step();
        chk("ab.req", 32'(ia.bus_req), 32'd1);
        ia.cop_mem_cen = 1'b0;
        step();
        chk("ab.req_off", 32'(ia.bus_req), 32'd0);
        step();
        chk("ab.no_rsp", 32'(ia.cop_mem_stall), 32'd1);
        load_a("be", 32'h0000_0600, 32'h0BAD_0600, 1'b1);

        // Test 6: reset during WAIT abandons the transaction
        ia.cop_mem_cen  = 1'b1;
        ia.cop_mem_addr = 32'h0000_0400;
        step();
        ia.bus_gnt = 1'b1;
        step();
        ia.bus_gnt     = 1'b0;
        ia.cop_mem_cen = 1'b0;
        g_resetn       = 1'b0;
        step();
        chk("t6.req",   32'(ia.bus_req), 32'd0);
        chk("t6.stall", 32'(ia.cop_mem_stall), 32'd1);
        chk("t6.err",   32'(ia.cop_mem_error), 32'd0);
        g_resetn = 1'b1;
        load_a("t6.after", 32'h0000_0408, 32'h5A5A_0408, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
